// File: rtl/value_buffer_alloc_if.sv
// Dispatch/issue bus for the value buffer allocator: grant requests,
// returned pointers, release strobes, flush and status.
interface value_buffer_alloc_if #(
  parameter int BUFFER_SEL = 5
);
  logic                  req_1;
  logic                  req_2;
  logic                  stall;
  logic [BUFFER_SEL-1:0] alloc_ptr_1;
  logic [BUFFER_SEL-1:0] alloc_ptr_2;
  logic                  alloc_valid_1;
  logic                  alloc_valid_2;
  logic                  full_stall;
  logic                  rel_valid_1;
  logic                  rel_valid_2;
  logic                  rel_valid_3;
  logic [BUFFER_SEL-1:0] rel_ptr_1;
  logic [BUFFER_SEL-1:0] rel_ptr_2;
  logic [BUFFER_SEL-1:0] rel_ptr_3;
  logic                  flush;
  logic [BUFFER_SEL:0]   free_count;
  logic                  err;

  modport master (
    output req_1, req_2, stall, rel_valid_1, rel_valid_2, rel_valid_3,
           rel_ptr_1, rel_ptr_2, rel_ptr_3, flush,
    input  alloc_ptr_1, alloc_ptr_2, alloc_valid_1, alloc_valid_2,
           full_stall, free_count, err
  );

  modport slave (
    input  req_1, req_2, stall, rel_valid_1, rel_valid_2, rel_valid_3,
           rel_ptr_1, rel_ptr_2, rel_ptr_3, flush,
    output alloc_ptr_1, alloc_ptr_2, alloc_valid_1, alloc_valid_2,
           full_stall, free_count, err
  );
endinterface

// File: rtl/value_buffer_alloc.sv
// Free-list allocator for the immediate/PC value buffer: two lowest-index
// grants per cycle at dispatch, up to three releases per cycle from issue.
module value_buffer_alloc #(
  parameter int BUFFER_NUM = 32,
  parameter int BUFFER_SEL = 5
) (
  input logic                 clk,
  input logic                 reset,
  value_buffer_alloc_if.slave bus
);
  localparam int CNT_W = BUFFER_SEL + 1;

  logic [BUFFER_NUM-1:0] free_map;
  logic [CNT_W-1:0]      free_cnt;
  logic                  err_q;

  logic [BUFFER_SEL-1:0] pick_a;
  logic [BUFFER_SEL-1:0] pick_b;
  logic                  found_a;
  logic                  found_b;
  logic [CNT_W-1:0]      req_sum;
  logic                  full;
  logic                  grant_1;
  logic                  grant_2;
  logic                  commit;
  logic [BUFFER_SEL-1:0] ptr_1;
  logic [BUFFER_SEL-1:0] ptr_2;
  logic [BUFFER_NUM-1:0] map_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  logic                  err_nxt;

  // Two lowest free entries of the registered map; releases this cycle are not visible yet.
  always_comb begin
    pick_a  = '0;
    pick_b  = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int i = 0; i < BUFFER_NUM; i++) begin
      if (free_map[i]) begin
        if (!found_a) begin
          pick_a  = BUFFER_SEL'(i);
          found_a = 1'b1;
        end else if (!found_b) begin
          pick_b  = BUFFER_SEL'(i);
          found_b = 1'b1;
        end
      end
    end
  end

  assign req_sum = CNT_W'(bus.req_1) + CNT_W'(bus.req_2);
  assign full    = req_sum > free_cnt;
  assign grant_1 = bus.req_1 & ~full;
  assign grant_2 = bus.req_2 & ~full;
  assign commit  = ~bus.stall & ~full & ~bus.flush;
  assign ptr_1   = bus.req_1 ? pick_a : '0;
  assign ptr_2   = bus.req_2 ? (bus.req_1 ? pick_b : pick_a) : '0;

  always_comb begin
    map_nxt = free_map;
    err_nxt = err_q;
    if (commit) begin
      if (grant_1) map_nxt[ptr_1] = 1'b0;
      if (grant_2) map_nxt[ptr_2] = 1'b0;
    end
    // Releasing a free entry only flags err; setting the bit again is harmless.
    if (bus.rel_valid_1) begin
      if (free_map[bus.rel_ptr_1]) err_nxt = 1'b1;
      map_nxt[bus.rel_ptr_1] = 1'b1;
    end
    if (bus.rel_valid_2) begin
      if (free_map[bus.rel_ptr_2]) err_nxt = 1'b1;
      map_nxt[bus.rel_ptr_2] = 1'b1;
    end
    if (bus.rel_valid_3) begin
      if (free_map[bus.rel_ptr_3]) err_nxt = 1'b1;
      map_nxt[bus.rel_ptr_3] = 1'b1;
    end
    if (bus.flush) begin
      map_nxt = '1;
      err_nxt = err_q;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < BUFFER_NUM; i++) cnt_nxt = cnt_nxt + CNT_W'(map_nxt[i]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_map <= '1;
      free_cnt <= CNT_W'(BUFFER_NUM);
      err_q    <= 1'b0;
    end else begin
      free_map <= map_nxt;
      free_cnt <= cnt_nxt;
      err_q    <= err_nxt;
    end
  end

  assign bus.alloc_ptr_1   = ptr_1;
  assign bus.alloc_ptr_2   = ptr_2;
  assign bus.alloc_valid_1 = grant_1;
  assign bus.alloc_valid_2 = grant_2;
  assign bus.full_stall    = full;
  assign bus.free_count    = free_cnt;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_value_buffer_alloc.sv
// Randomized + directed bench for value_buffer_alloc with a free-list queue
// reference model and a negedge scoreboard monitor.
module tb_value_buffer_alloc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  value_buffer_alloc_if #(.BUFFER_SEL(5)) bus();

  value_buffer_alloc #(.BUFFER_NUM(32), .BUFFER_SEL(5)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    bit r1, r2, v1, v2, fs, err;
    int p1, p2, cnt;
  } exp_t;

  exp_t sb[$];
  int   free_q[$];
  bit   m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit q_has(input int q[$], input int x);
    foreach (q[i]) if (q[i] == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void q_remove(input int x);
    foreach (free_q[i]) if (free_q[i] == x) begin
      free_q.delete(i);
      return;
    end
  endfunction

  function automatic void model_reset();
    free_q.delete();
    for (int i = 0; i < 32; i++) free_q.push_back(i);
    m_err = 1'b0;
  endfunction

  function automatic void model_update(input exp_t e, input bit st, input bit fl,
                                       input bit v1, input int p1, input bit v2, input int p2,
                                       input bit v3, input int p3);
    int pre[$];
    bit rv[3];
    int rp[3];
    if (fl) begin
      free_q.delete();
      for (int i = 0; i < 32; i++) free_q.push_back(i);
      return;
    end
    pre = free_q;
    if (!st && !e.fs) begin
      if (e.v1) q_remove(e.p1);
      if (e.v2) q_remove(e.p2);
    end
    rv = '{v1, v2, v3};
    rp = '{p1, p2, p3};
    for (int k = 0; k < 3; k++) begin
      if (rv[k]) begin
        if (q_has(pre, rp[k])) m_err = 1'b1;
        else if (!q_has(free_q, rp[k])) free_q.push_back(rp[k]);
      end
    end
    free_q.sort();
  endfunction

  // One clock of stimulus: drive, predict, then advance the model at the edge.
  task automatic step(input bit r1, input bit r2, input bit st, input bit fl,
                      input bit v1, input int p1, input bit v2, input int p2,
                      input bit v3, input int p3);
    exp_t e;
    int n, a, b;
    bus.req_1 = r1; bus.req_2 = r2; bus.stall = st; bus.flush = fl;
    bus.rel_valid_1 = v1; bus.rel_ptr_1 = 5'(p1);
    bus.rel_valid_2 = v2; bus.rel_ptr_2 = 5'(p2);
    bus.rel_valid_3 = v3; bus.rel_ptr_3 = 5'(p3);
    n = int'(r1) + int'(r2);
    a = (free_q.size() > 0) ? free_q[0] : 0;
    b = (free_q.size() > 1) ? free_q[1] : 0;
    e.r1 = r1; e.r2 = r2;
    e.fs = n > free_q.size();
    e.p1 = r1 ? a : 0;
    e.p2 = r2 ? (r1 ? b : a) : 0;
    e.v1 = r1 && !e.fs;
    e.v2 = r2 && !e.fs;
    e.cnt = free_q.size();
    e.err = m_err;
    sb.push_back(e);
    @(posedge clk);
    model_update(e, st, fl, v1, p1, v2, p2, v3, p3);
    #1;
  endtask

  task automatic alloc(input bit r1, input bit r2, input bit st);
    step(r1, r2, st, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
  endtask

  function automatic int pick_alloc();
    int cand[$];
    for (int i = 0; i < 32; i++) if (!q_has(free_q, i)) cand.push_back(i);
    if (cand.size() == 0) return int'($urandom_range(31));
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("full_stall", int'(bus.full_stall), int'(e.fs));
        check("alloc_valid_1", int'(bus.alloc_valid_1), int'(e.v1));
        check("alloc_valid_2", int'(bus.alloc_valid_2), int'(e.v2));
        if (!e.r1 || e.v1) check("alloc_ptr_1", int'(bus.alloc_ptr_1), e.p1);
        if (!e.r2 || e.v2) check("alloc_ptr_2", int'(bus.alloc_ptr_2), e.p2);
        check("free_count", int'(bus.free_count), e.cnt);
        check("err", int'(bus.err), int'(e.err));
      end
    end
  end

  initial begin : stim
    bit r1, r2, st, fl, v1, v2, v3;
    int p1, p2, p3;
    bus.req_1 = 1'b0; bus.req_2 = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.rel_valid_1 = 1'b0; bus.rel_valid_2 = 1'b0; bus.rel_valid_3 = 1'b0;
    bus.rel_ptr_1 = '0; bus.rel_ptr_2 = '0; bus.rel_ptr_3 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_free_count", int'(bus.free_count), 32);
    check("reset_err", int'(bus.err), 0);
    check("reset_full_stall", int'(bus.full_stall), 0);

    // Back-to-back double grants and a stalled double grant.
    alloc(1'b0, 1'b0, 1'b0);
    repeat (3) alloc(1'b1, 1'b1, 1'b0);
    check("after_3_pairs", int'(bus.free_count), 26);
    repeat (2) alloc(1'b1, 1'b1, 1'b1);
    check("stall_hold", int'(bus.free_count), 26);
    alloc(1'b1, 1'b1, 1'b0);
    check("stall_release", int'(bus.free_count), 24);

    // Fill to 31 allocated, then exercise the full boundary.
    repeat (11) alloc(1'b1, 1'b1, 1'b0);
    alloc(1'b1, 1'b0, 1'b0);
    check("one_left", int'(bus.free_count), 1);
    alloc(1'b1, 1'b1, 1'b0);
    check("full_no_partial", int'(bus.free_count), 1);
    alloc(1'b1, 1'b0, 1'b0);
    check("last_entry", int'(bus.free_count), 0);

    // Release while empty: the pick still sees the pre-release map.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 9, 1'b0, 0);
    alloc(1'b1, 1'b0, 1'b0);
    check("after_rel_alloc", int'(bus.free_count), 1);

    // Double release of a free entry plus a duplicate across ports.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9, 1'b1, 4, 1'b1, 4);
    check("dup_release_count", int'(bus.free_count), 2);
    check("err_set", int'(bus.err), 1);

    // Flush from 20 allocated with a competing request and release.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    repeat (10) alloc(1'b1, 1'b1, 1'b0);
    check("twenty_alloc", int'(bus.free_count), 12);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5, 1'b0, 0, 1'b0, 0);
    check("flush_count", int'(bus.free_count), 32);
    check("flush_keeps_err", int'(bus.err), 1);
    alloc(1'b1, 1'b0, 1'b0);
    alloc(1'b1, 1'b1, 1'b1);

    // Async reset asserted mid-cycle while stalled.
    bus.req_1 = 1'b1; bus.req_2 = 1'b1; bus.stall = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_free_count", int'(bus.free_count), 32);
    check("async_err", int'(bus.err), 0);
    check("async_ptr_1", int'(bus.alloc_ptr_1), 0);
    check("async_ptr_2", int'(bus.alloc_ptr_2), 1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic, mostly legal releases.
    for (int c = 0; c < 400; c++) begin
      r1 = ($urandom_range(3) != 0);
      r2 = ($urandom_range(3) != 0);
      st = ($urandom_range(3) == 0);
      fl = ($urandom_range(39) == 0);
      v1 = ($urandom_range(2) == 0);
      v2 = ($urandom_range(3) == 0);
      v3 = ($urandom_range(4) == 0);
      p1 = ($urandom_range(19) == 0) ? int'($urandom_range(31)) : pick_alloc();
      p2 = pick_alloc();
      p3 = ($urandom_range(9) == 0) ? p2 : pick_alloc();
      step(r1, r2, st, fl, v1, p1, v2, p2, v3, p3);
    end
    alloc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
